// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480 VGA timing constants and derived-size helpers
// Shared by the frame counter and the porch generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam bit DEF_H_POL      = 1'b0;
    localparam bit DEF_V_POL      = 1'b0;
    localparam int DEF_PIPE_DELAY = 2;

    function automatic int timing_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // A one-position axis still needs a one-bit counter.
    function automatic int counter_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
    localparam int DEF_COL_W   = counter_width(DEF_H_TOTAL);
    localparam int DEF_ROW_W   = counter_width(DEF_V_TOTAL);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
    } sync_flags_t;

endpackage

// File: rtl/vga_frame_counter.sv
// rtl/vga_frame_counter.sv - column/row counter resynchronised on every VSync rising edge
// A rising edge forces (0,0) and overrides any wrap in the same cycle.
module vga_frame_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int COL_W   = counter_width(H_TOTAL),
    parameter int ROW_W   = counter_width(V_TOTAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vsync,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             vsync_prev_q, vsync_prev_d;
    logic             frame_edge;
    logic             col_last;
    logic             row_last;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        vsync_prev_d = i_vsync;
        frame_edge   = i_vsync && !vsync_prev_q;
        col_last     = (col_q == COL_W'(H_TOTAL - 1));
        row_last     = (row_q == ROW_W'(V_TOTAL - 1));

        if (frame_edge) begin
            col_d = '0;
            row_d = '0;
        end else if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            vsync_prev_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    assign o_col = col_q;
    assign o_row = row_q;

endmodule

// File: rtl/vga_sync_porch_gen.sv
// rtl/vga_sync_porch_gen.sv - porched HSync/VSync, active and frame-start with aligned video delay
// Define VGA_PORCH_BLANK_EN to force video to zero outside the visible area.
module vga_sync_porch_gen
    import vga_timing_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit H_POL       = DEF_H_POL,
    parameter bit V_POL       = DEF_V_POL,
    parameter int PIPE_DELAY  = DEF_PIPE_DELAY
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Active,
    output logic                   o_Frame_Start
);

    localparam int H_TOTAL      = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL      = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int COL_W        = counter_width(H_TOTAL);
    localparam int ROW_W        = counter_width(V_TOTAL);
    localparam int H_SYNC_FIRST = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
    localparam int V_SYNC_FIRST = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;
    // The counter itself supplies one cycle of latency to the flag path.
    localparam int SYNC_STAGES  = PIPE_DELAY - 1;

    typedef struct packed {
        logic [VIDEO_WIDTH-1:0] red;
        logic [VIDEO_WIDTH-1:0] grn;
        logic [VIDEO_WIDTH-1:0] blu;
    } pixel_t;

    localparam sync_flags_t FLAGS_RST = {~H_POL, ~V_POL, 1'b0, 1'b0};

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    sync_flags_t      pixel_flags;
    sync_flags_t      sync_pipe_q [SYNC_STAGES];
    sync_flags_t      sync_pipe_d [SYNC_STAGES];
    pixel_t           vid_pipe_q  [PIPE_DELAY];
    pixel_t           vid_pipe_d  [PIPE_DELAY];
    sync_flags_t      out_flags;
    pixel_t           out_pixel;
    logic             unused_hsync;

    // Position is rebuilt from the frame edge alone; i_HSync only marks where the video is valid.
    assign unused_hsync = i_HSync;

    vga_frame_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_frame_counter (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .i_vsync (i_VSync),
        .o_col   (col),
        .o_row   (row)
    );

    always_comb begin
        pixel_flags             = FLAGS_RST;
        pixel_flags.hsync       = ((col >= COL_W'(H_SYNC_FIRST)) && (col <= COL_W'(H_SYNC_LAST)))
                                  ? H_POL : ~H_POL;
        pixel_flags.vsync       = ((row >= ROW_W'(V_SYNC_FIRST)) && (row <= ROW_W'(V_SYNC_LAST)))
                                  ? V_POL : ~V_POL;
        pixel_flags.active      = (col < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE));
        pixel_flags.frame_start = (col == '0) && (row == '0);
    end

    always_comb begin
        sync_pipe_d    = sync_pipe_q;
        sync_pipe_d[0] = pixel_flags;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_pipe_d[i] = sync_pipe_q[i-1];
        end

        vid_pipe_d    = vid_pipe_q;
        vid_pipe_d[0] = '{red: i_Red_Video, grn: i_Grn_Video, blu: i_Blu_Video};
        for (int i = 1; i < PIPE_DELAY; i++) begin
            vid_pipe_d[i] = vid_pipe_q[i-1];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe_q[i] <= FLAGS_RST;
            end
            for (int i = 0; i < PIPE_DELAY; i++) begin
                vid_pipe_q[i] <= '0;
            end
        end else begin
            sync_pipe_q <= sync_pipe_d;
            vid_pipe_q  <= vid_pipe_d;
        end
    end

    assign out_flags = sync_pipe_q[SYNC_STAGES-1];

`ifdef VGA_PORCH_BLANK_EN
    assign out_pixel = out_flags.active ? vid_pipe_q[PIPE_DELAY-1] : '0;
`else
    assign out_pixel = vid_pipe_q[PIPE_DELAY-1];
`endif

    assign o_HSync       = out_flags.hsync;
    assign o_VSync       = out_flags.vsync;
    assign o_Active      = out_flags.active;
    assign o_Frame_Start = out_flags.frame_start;
    assign o_Red_Video   = out_pixel.red;
    assign o_Grn_Video   = out_pixel.grn;
    assign o_Blu_Video   = out_pixel.blu;

endmodule

// File: tb/tb_vga_sync_porch_gen.sv
// tb/tb_vga_sync_porch_gen.sv - three reduced-timing instances checked against a position/latency model
module tb_vga_sync_porch_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 5, HT = HA + HF + HS + HB;
    localparam int VA = 10, VF = 2, VS = 3, VB = 2, VT = VA + VF + VS + VB;
    localparam int PD_A = 2, PD_B = 5, PD_C = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, hs_in, vs_in;
    logic [2:0] red_in, grn_in, blu_in;
    logic       a_hs, a_vs, a_act, a_fs, b_hs, b_vs, b_act, b_fs, c_hs, c_vs, c_act, c_fs;
    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    vga_sync_porch_gen #(.VIDEO_WIDTH(3), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_POL(1'b0), .V_POL(1'b0),
        .PIPE_DELAY(PD_A)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_in), .i_VSync(vs_in),
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_HSync(a_hs), .o_VSync(a_vs), .o_Red_Video(a_r), .o_Grn_Video(a_g), .o_Blu_Video(a_b),
        .o_Active(a_act), .o_Frame_Start(a_fs));

    vga_sync_porch_gen #(.VIDEO_WIDTH(3), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_POL(1'b0), .V_POL(1'b0),
        .PIPE_DELAY(PD_B)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_in), .i_VSync(vs_in),
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_HSync(b_hs), .o_VSync(b_vs), .o_Red_Video(b_r), .o_Grn_Video(b_g), .o_Blu_Video(b_b),
        .o_Active(b_act), .o_Frame_Start(b_fs));

    vga_sync_porch_gen #(.VIDEO_WIDTH(3), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_POL(1'b1), .V_POL(1'b1),
        .PIPE_DELAY(PD_C)) dut_c (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_in), .i_VSync(vs_in),
        .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
        .o_HSync(c_hs), .o_VSync(c_vs), .o_Red_Video(c_r), .o_Grn_Video(c_g), .o_Blu_Video(c_b),
        .o_Active(c_act), .o_Frame_Start(c_fs));

    typedef struct {
        bit         rst;
        int         c;
        int         r;
        logic [8:0] vid;
    } samp_t;

    samp_t hist[$];
    int    n_pos = 0;
    bit    prev_v = 1'b0;
    int    last_rise = -1;
    int    n_assert = 0;
    int    n_fail = 0;
    int    gc, gr;
    bit    glitch;
    bit    inject_pending = 1'b0;
    int    inj_r, inj_c;

    // Reference: position = samples since the last frame edge (or reset), folded by the totals.
    task automatic record();
        samp_t s;
        bit    rise;
        rise = !rst && vs_in && !prev_v;
        if (rst || rise) n_pos = 0;
        else             n_pos++;
        prev_v = rst ? 1'b0 : vs_in;
        s.rst = rst;
        s.c   = n_pos % HT;
        s.r   = (n_pos / HT) % VT;
        s.vid = {red_in, grn_in, blu_in};
        hist.push_back(s);
        if (rise) last_rise = hist.size() - 1;
    endtask

    function automatic logic [12:0] expect_out(input int k, input int pd, input bit hp, input bit vp);
        samp_t      s;
        int         j;
        logic       hx, vx, act, fs;
        logic [8:0] vid;
        for (int i = k - pd + 2; i <= k; i++)
            if (i >= 0 && hist[i].rst) return {~hp, ~vp, 2'b00, 9'd0};
        j = k - pd + 1;
        if (j < 0) return {~hp, ~vp, 2'b00, 9'd0};
        s   = hist[j];
        hx  = (s.c >= HA + HF && s.c < HA + HF + HS) ? hp : ~hp;
        vx  = (s.r >= VA + VF && s.r < VA + VF + VS) ? vp : ~vp;
        act = (s.c < HA) && (s.r < VA);
        fs  = (s.c == 0) && (s.r == 0);
        vid = s.rst ? 9'd0 : s.vid;
`ifdef VGA_PORCH_BLANK_EN
        if (!act) vid = 9'd0;
`endif
        return {hx, vx, act, fs, vid};
    endfunction

    task automatic drive();
        hs_in  = (gc < HA);
        vs_in  = glitch ? 1'b0 : (gr < VA);
        red_in = 3'(gc % 8);
        grn_in = 3'($urandom_range(0, 7));
        blu_in = 3'($urandom_range(0, 7));
    endtask

    task automatic advance();
        if (glitch) begin
            glitch = 1'b0;
            gc = 0;
            gr = 0;
        end else begin
            gc++;
            if (gc == HT) begin
                gc = 0;
                gr = (gr == VT - 1) ? 0 : gr + 1;
            end
            if (inject_pending && gr == inj_r && gc == inj_c) begin
                glitch = 1'b1;
                inject_pending = 1'b0;
            end
        end
        drive();
    endtask

    task automatic check_one(input string tag, input int k, input logic [12:0] obs, input logic [12:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        int k;
        record();
        k = hist.size() - 1;
        @(posedge clk);
        #1;
        check_one("dut_a", k, {a_hs, a_vs, a_act, a_fs, a_r, a_g, a_b}, expect_out(k, PD_A, 1'b0, 1'b0));
        check_one("dut_b", k, {b_hs, b_vs, b_act, b_fs, b_r, b_g, b_b}, expect_out(k, PD_B, 1'b0, 1'b0));
        check_one("dut_c", k, {c_hs, c_vs, c_act, c_fs, c_r, c_g, c_b}, expect_out(k, PD_C, 1'b1, 1'b1));
        advance();
    endtask

    task automatic check_bit(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int  cnt_act, cnt_hlow, cnt_vlow, drop_at, guard, rise_k;
        bit  found;

        gc = 0; gr = VT - 3; glitch = 1'b0;
        rst = 1'b1;
        drive();
        step();
        check_bit("reset_a_levels", {a_hs, a_vs, a_act, a_fs}, 4'b1100);
        check_bit("reset_c_levels", {c_hs, c_vs, c_act, c_fs}, 4'b0000);
        check_bit("reset_b_video", {b_r, b_g, b_b}, 0);
        step();
        rst = 1'b0;
        drive();
        repeat (2 * HT * VT) step();

        // Early frame edge in the middle of the visible rows.
        inj_r = $urandom_range(2, VA - 2);
        inj_c = $urandom_range(0, HT - 1);
        inject_pending = 1'b1;
        guard = 0;
        while ((inject_pending || glitch) && guard < 2 * HT * VT) begin
            step();
            guard++;
        end
        check_bit("inject_happened", inject_pending || glitch, 0);
        rise_k = -1;
        found = 1'b0;
        guard = 0;
        while (guard < 8) begin
            step();
            if (last_rise >= 0 && hist.size() - 1 == last_rise + PD_A - 1 && rise_k < 0) begin
                rise_k = last_rise;
                check_bit("early_fs_a", a_fs, 1);
            end
            if (rise_k >= 0 && hist.size() - 1 == rise_k + PD_B - 1) begin
                check_bit("early_fs_b", b_fs, 1);
                found = 1'b1;
            end
            guard++;
        end
        check_bit("early_fs_seen", found, 1);
        repeat (HT * VT) step();

        // Reset for three clocks mid-line.
        guard = 0;
        while (gc != HA / 2 && guard < 2 * HT) begin step(); guard++; end
        rst = 1'b1;
        drive();
        step();
        check_bit("midline_reset_a", {a_hs, a_vs, a_act, a_fs, a_r, a_g, a_b}, {4'b1100, 9'd0});
        check_bit("midline_reset_c", {c_hs, c_vs, c_act, c_fs}, 4'b0000);
        step();
        step();
        rst = 1'b0;
        drive();
        repeat (2 * HT * VT) step();

        // Line and frame shape on dut_a starting from its frame-start pulse.
        found = 1'b0;
        guard = 0;
        while (!found && guard < 2 * HT * VT) begin
            step();
            if (a_fs === 1'b1) found = 1'b1;
            guard++;
        end
        check_bit("fs_found", found, 1);
        check_bit("fs_red_zero", a_r, 0);
        check_bit("fs_active", a_act, 1);
        cnt_act = 0; cnt_hlow = 0; cnt_vlow = 0; drop_at = -1;
        for (int i = 0; i < HT * VT; i++) begin
            if (i < HT) begin
                if (a_act) cnt_act++;
                if (!a_hs) cnt_hlow++;
                if (!a_act && drop_at < 0) drop_at = i;
            end
            if (!a_vs) cnt_vlow++;
            step();
        end
        check_bit("line_active_count", cnt_act, HA);
        check_bit("active_drop_offset", drop_at, HA);
        check_bit("line_hsync_low", cnt_hlow, HS);
        check_bit("frame_vsync_low", cnt_vlow, VS * HT);
        check_bit("next_frame_start", a_fs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
